// File: rtl/cpu_debug_slave_cmd_sync.sv
// Clock-domain side of the CPU debug slave: synchronises TCK update strobes,
// queues each update-DR as a command and issues one-hot action pulses on pop.
module cpu_debug_slave_cmd_sync #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [SR_W-1:0]               sr,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [IR_W-1:0]               cmd_ir,
  output logic [SR_W-1:0]               jdo,
  output logic [(2**IR_W)-1:0]          take_action,
  output logic [(2**IR_W)-1:0]          take_no_action,
  output logic                          ir_update,
  output logic [IR_W-1:0]               ir_shadow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = IR_W + SR_W;

  logic [SYNC_STAGES-1:0] udrSync_q, uirSync_q;
  logic                   udrPrev_q, uirPrev_q;
  logic                   udrEdge, uirEdge;

  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic [LVL_W-1:0]       wrPtr_q, wrPtr_d;
  logic [LVL_W-1:0]       rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]       level;
  logic                   full, pop, pushEn;
  logic                   overflow_q, overflow_d;
  logic [IR_W-1:0]        irShadow_q, irShadow_d;
  logic                   irUpdate_q;
  logic [ENTRY_W-1:0]     head;

  // The prev flop starts at 0, so a strobe held high across reset release
  // is seen as a fresh rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udrSync_q <= '0;
      uirSync_q <= '0;
      udrPrev_q <= 1'b0;
      uirPrev_q <= 1'b0;
    end else begin
      udrSync_q <= {udrSync_q[SYNC_STAGES-2:0], vs_udr};
      uirSync_q <= {uirSync_q[SYNC_STAGES-2:0], vs_uir};
      udrPrev_q <= udrSync_q[SYNC_STAGES-1];
      uirPrev_q <= uirSync_q[SYNC_STAGES-1];
    end
  end

  assign udrEdge = udrSync_q[SYNC_STAGES-1] & ~udrPrev_q;
  assign uirEdge = uirSync_q[SYNC_STAGES-1] & ~uirPrev_q;

  assign level     = wrPtr_q - rdPtr_q;
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign cmd_valid = (level != '0);
  assign pop       = cmd_valid & cmd_ready;

  // A push into a full queue is only accepted when the head leaves this cycle.
  always_comb begin
    pushEn     = udrEdge & (~full | pop);
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    overflow_d = overflow_q;
    irShadow_d = irShadow_q;
    if (pushEn) wrPtr_d = wrPtr_q + LVL_W'(1);
    if (pop)    rdPtr_d = rdPtr_q + LVL_W'(1);
    if (clear_overflow)
      overflow_d = 1'b0;
    else if (udrEdge & full & ~pop)
      overflow_d = 1'b1;
    if (uirEdge) irShadow_d = ir_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
      irShadow_q <= '0;
      irUpdate_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      overflow_q <= overflow_d;
      irShadow_q <= irShadow_d;
      irUpdate_q <= uirEdge;
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wrPtr_q[PTR_W-1:0]] <= {ir_in, sr};
  end

  // Head fields read as zero while empty so stale storage never leaks out.
  assign head   = mem_q[rdPtr_q[PTR_W-1:0]];
  assign cmd_ir = cmd_valid ? head[ENTRY_W-1 -: IR_W] : '0;
  assign jdo    = cmd_valid ? head[SR_W-1:0] : '0;

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (jdo[ACT_BIT]) take_action[cmd_ir]    = 1'b1;
      else              take_no_action[cmd_ir] = 1'b1;
    end
  end

  assign ir_update  = irUpdate_q;
  assign ir_shadow  = irShadow_q;
  assign fifo_level = level;
  assign overflow   = overflow_q;

endmodule
